decode_issue_stage: RTL and testbench
=====================================

# decode_issue_stage

Parametrised decode/issue stage for the pipelined RISC-V core. It takes pre-decoded instruction fields from the combinational decoder and reads both source operands from an internal register file. A per-register pending-write scoreboard holds issue while a source is not yet available, and bypasses same-cycle writeback data when it is. The result is a registered issue packet delivered to the execute stage over a valid/ready handshake.

## Interface
- XLEN, 32: data width of registers and operands.
- NREGS, 32: architectural register count, a power of two, at least 2; index 0 is hard-wired zero.
- CNT_W, 2: width of each per-register pending-write counter; saturates at 2^CNT_W−1.
- CTRL_W, 32: width of the opaque control payload passed through to execute.
- CLK  in  1  single clock; all state updates on rising edge.
- RST_N  in  1  synchronous, active-low reset.
- IN_VALID  in  1  decoder presents an instruction.
- IN_READY  out  1  stage accepts the instruction this cycle.
- IN_RS1, IN_RS2  in  log2(NREGS)  source indices.
- IN_USES_RS1, IN_USES_RS2  in  1  source is actually read.
- IN_RD  in  log2(NREGS)  destination index.
- IN_RD_WEN  in  1  instruction writes IN_RD.
- IN_CTRL  in  CTRL_W  control payload (ALU op, imm, etc.).
- WB_VALID  in  1  one in-flight writer retires this cycle.
- WB_WEN  in  1  with WB_VALID: 1 = write WB_DATA, 0 = cancelled retire (flushed), counter decrement only.
- WB_DES  in  log2(NREGS)  retiring destination.
- WB_DATA  in  XLEN  writeback value.
- FLUSH  in  1  kill the held output packet; block issue this cycle.
- OUT_VALID  out  1  issue packet valid.
- OUT_READY  in  1  execute consumes the packet.
- OUT_RS1_DATA, OUT_RS2_DATA  out  XLEN  operands.
- OUT_RD  out  log2(NREGS); OUT_RD_WEN  out  1; OUT_CTRL  out  CTRL_W.
- ERR  out  1  sticky: a decrement hit a zero counter.

## Operation
- Scoreboard: cnt[r] for r≥1 counts issued-but-not-retired writers of r. cnt[0] is always 0, and writes to x0 are ignored everywhere.
- Per-cycle counter delta for register r: +1 if an issue with IN_RD_WEN and IN_RD==r occurs; −1 if WB_VALID and WB_DES==r; −1 if FLUSH kills a valid output packet with OUT_RD_WEN and OUT_RD==r. Apply the net delta, so simultaneous +1 and −1 leaves cnt unchanged.
- Underflow: any decrement of a zero counter is dropped, and ERR is set to 1 until reset.
- Source ready when any of the following holds:
  - the source is unused;
  - the index is 0;
  - cnt==0;
  - cnt==1 and WB_VALID & WB_WEN & WB_DES==index (bypass WB_DATA).
- Register-file read is write-first for the same index.
- Issue condition, also driving IN_READY: !FLUSH & both sources ready & !(IN_RD_WEN & cnt[IN_RD] saturated) & (!OUT_VALID | OUT_READY). IN_READY does not depend on IN_VALID.
- Issue happens when IN_VALID & IN_READY. Operands, RD, RD_WEN and CTRL are loaded into the output register, and OUT_VALID goes to 1.
- The output packet stays stable while OUT_VALID & !OUT_READY. It clears on OUT_READY without a new issue.
- FLUSH clears OUT_VALID regardless of OUT_READY. A packet consumed in the FLUSH cycle counts as killed, not issued downstream.
- Reset clears all counters, OUT_VALID, OUT_RD, OUT_RD_WEN, OUT_CTRL, OUT_RS*_DATA, and ERR. Register-file contents are not reset, except x0, which reads 0.

## Timing
- Latency: instruction accepted at edge N gives OUT_VALID high after edge N, so operands are visible in cycle N+1.
- Throughput: one instruction per cycle when OUT_READY stays high and there are no hazards.
- Writeback at edge N is visible to a read in cycle N+1 from the register file. In cycle N itself it is visible through the bypass.
- IN_READY is combinational from the scoreboard, WB_* inputs, FLUSH, OUT_VALID and OUT_READY. There is no path from IN_VALID.
- RST_N low at any edge overrides issue, writeback counting and FLUSH. In-flight packets are discarded.

## Structure
- Shared package decode_pkg holds:
  - the idx width function clog2(NREGS);
  - the issue-packet struct {rs1_data, rs2_data, rd, rd_wen, ctrl};
  - the constant ZERO_REG=0.
- One sub-module, regfile_2r1w: parametrised XLEN/NREGS, two async read ports, one sync write port, write-first forwarding, x0 forced to zero.
- Scoreboard, issue logic and output register live in the top module.

## Test plan
- Reset, then write x5=0x1234 via WB; next cycle issue add rs1=x5 → OUT_RS1_DATA=0x1234, OUT_VALID one cycle after accept.
- RAW hazard:
  - issue rd=x3, then an instruction reading x3 → IN_READY=0;
  - WB x3=0xAA arrives → same-cycle bypass, issue with OUT_RS1_DATA=0xAA.
- Two writers of x7 (cnt=2):
  - first WB gives no bypass, reader stalls;
  - second WB with 0x55 bypasses → operand 0x55.
- OUT_READY low for 3 cycles with OUT_VALID high → packet stable and IN_READY=0; OUT_READY high → next instruction issues the same edge.
- FLUSH with a valid output packet having rd=x9 → OUT_VALID=0 next cycle, cnt[x9] back to 0, and a reader of x9 issues immediately.
- WB_VALID to x4 with cnt[x4]=0 → ERR=1 and stays 1 until RST_N low; write to x0 → reads remain 0.

Source files
------------

// File: rtl/decode_pkg.sv
// decode_pkg: shared constants, index-width helper and issue-packet layout
package decode_pkg;
  localparam int ZERO_REG = 0;
  localparam int XLEN_DEF = 32;
  localparam int NREGS_DEF = 32;
  localparam int CTRL_W_DEF = 32;
  function automatic int idx_w(input int nregs);
    return $clog2(nregs);
  endfunction
  typedef struct packed {
    logic [XLEN_DEF-1:0] rs1_data;
    logic [XLEN_DEF-1:0] rs2_data;
    logic [$clog2(NREGS_DEF)-1:0] rd;
    logic rd_wen;
    logic [CTRL_W_DEF-1:0] ctrl;
  } issue_pkt_t;
endpackage

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: two async read ports, one sync write port, write-first, x0 reads zero
module regfile_2r1w
  import decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  localparam int IW = idx_w(NREGS)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [IW-1:0]   wa,
  input  logic [XLEN-1:0] wd,
  input  logic [IW-1:0]   ra1,
  input  logic [IW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);
  logic [XLEN-1:0] mem [NREGS];
  always_ff @(posedge clk) if (we && wa != IW'(ZERO_REG)) mem[wa] <= wd;
  assign rd1 = ra1 == IW'(ZERO_REG) ? '0 : (we && wa == ra1) ? wd : mem[ra1];
  assign rd2 = ra2 == IW'(ZERO_REG) ? '0 : (we && wa == ra2) ? wd : mem[ra2];
endmodule

// File: rtl/decode_issue_stage.sv
// decode_issue_stage: scoreboarded operand read with writeback bypass and registered issue packet
module decode_issue_stage
  import decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  parameter int CNT_W = 2,
  parameter int CTRL_W = 32,
  localparam int IW = idx_w(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IW-1:0]     in_rs1,
  input  logic [IW-1:0]     in_rs2,
  input  logic              in_uses_rs1,
  input  logic              in_uses_rs2,
  input  logic [IW-1:0]     in_rd,
  input  logic              in_rd_wen,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              wb_valid,
  input  logic              wb_wen,
  input  logic [IW-1:0]     wb_des,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_rs1_data,
  output logic [XLEN-1:0]   out_rs2_data,
  output logic [IW-1:0]     out_rd,
  output logic              out_rd_wen,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              err
);
  typedef struct packed {
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [IW-1:0]     rd;
    logic              rd_wen;
    logic [CTRL_W-1:0] ctrl;
  } pkt_t;
  logic [CNT_W-1:0] cnt_q [NREGS];
  logic [CNT_W-1:0] cnt_d [NREGS];
  pkt_t pkt_q, pkt_d;
  logic out_valid_q, out_valid_d, err_q, err_d;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic wb_fire, rs1_ok, rs2_ok, issue, kill;
  int nxt;
  regfile_2r1w #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
    .clk(clk),
    .we(wb_fire),
    .wa(wb_des),
    .wd(wb_data),
    .ra1(in_rs1),
    .ra2(in_rs2),
    .rd1(rs1_val),
    .rd2(rs2_val)
  );
  assign wb_fire = wb_valid & wb_wen;
  // a single outstanding writer retiring this cycle can be bypassed; older writers cannot
  assign rs1_ok = !in_uses_rs1 || in_rs1 == IW'(ZERO_REG) || cnt_q[in_rs1] == '0 ||
                  (cnt_q[in_rs1] == CNT_W'(1) && wb_fire && wb_des == in_rs1);
  assign rs2_ok = !in_uses_rs2 || in_rs2 == IW'(ZERO_REG) || cnt_q[in_rs2] == '0 ||
                  (cnt_q[in_rs2] == CNT_W'(1) && wb_fire && wb_des == in_rs2);
  assign in_ready = !flush && rs1_ok && rs2_ok && !(in_rd_wen && &cnt_q[in_rd]) &&
                    (!out_valid_q || out_ready);
  assign issue = in_valid & in_ready;
  assign kill = flush & out_valid_q & pkt_q.rd_wen;
  always_comb begin
    err_d = err_q;
    nxt = 0;
    cnt_d[0] = '0;
    for (int r = 1; r < NREGS; r++) begin
      nxt = int'(cnt_q[r]) + int'(issue && in_rd_wen && in_rd == IW'(r))
          - int'(wb_valid && wb_des == IW'(r)) - int'(kill && pkt_q.rd == IW'(r));
      err_d = err_d | (nxt < 0);
      cnt_d[r] = nxt < 0 ? '0 : CNT_W'(nxt);
    end
  end
  always_comb begin
    pkt_d = issue ? pkt_t'{rs1_data: rs1_val, rs2_data: rs2_val, rd: in_rd,
                           rd_wen: in_rd_wen, ctrl: in_ctrl} : pkt_q;
    out_valid_d = !flush && (issue || (out_valid_q && !out_ready));
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '{default: '0};
      pkt_q <= '0;
      out_valid_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pkt_q <= pkt_d;
      out_valid_q <= out_valid_d;
      err_q <= err_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_rs1_data = pkt_q.rs1_data;
  assign out_rs2_data = pkt_q.rs2_data;
  assign out_rd = pkt_q.rd;
  assign out_rd_wen = pkt_q.rd_wen;
  assign out_ctrl = pkt_q.ctrl;
  assign err = err_q;
endmodule

// File: tb/tb_decode_issue_stage.sv
// tb_decode_issue_stage: table vectors, directed corner sequences and random traffic vs a scoreboard model
module tb_decode_issue_stage;
  localparam int XLEN = 32, NREGS = 32, CNT_W = 2, CTRL_W = 32, IW = 5;
  localparam int CMAX = (1 << CNT_W) - 1;
  logic clk = 1'b0, rst_n;
  logic in_valid, in_ready, in_uses_rs1, in_uses_rs2, in_rd_wen;
  logic wb_valid, wb_wen, flush, out_valid, out_ready, out_rd_wen, err;
  logic [IW-1:0] in_rs1, in_rs2, in_rd, wb_des, out_rd;
  logic [XLEN-1:0] wb_data, out_rs1_data, out_rs2_data;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  int pass_n = 0, total_n = 0;
  int mcnt [NREGS];
  logic [31:0] mrf [NREGS];
  bit mknown [NREGS];
  bit mv, mrw, merr, mk1, mk2;
  logic [4:0] mrd;
  logic [31:0] mctrl, md1, md2;
  typedef struct {
    int iv, rs1, u1, rd, rw, wv, ww, wd, wdat, ir, ov, c1, d1;
  } vec_t;
  vec_t vt [10];

  decode_issue_stage #(.XLEN(XLEN), .NREGS(NREGS), .CNT_W(CNT_W), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_uses_rs1(in_uses_rs1), .in_uses_rs2(in_uses_rs2),
    .in_rd(in_rd), .in_rd_wen(in_rd_wen), .in_ctrl(in_ctrl),
    .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_des(wb_des), .wb_data(wb_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .out_rd(out_rd), .out_rd_wen(out_rd_wen), .out_ctrl(out_ctrl), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input int got, input int exp);
    total_n++;
    if (got != exp) $display("FAIL %s: got %h expected %h", n, got, exp);
    else pass_n++;
  endtask

  task automatic drive(input int iv, rs1, u1, rs2, u2, rd, rw, ctrl, wv, ww, wd, wdat, fl, ordy);
    in_valid = 1'(iv); in_rs1 = IW'(rs1); in_uses_rs1 = 1'(u1);
    in_rs2 = IW'(rs2); in_uses_rs2 = 1'(u2); in_rd = IW'(rd); in_rd_wen = 1'(rw);
    in_ctrl = 32'(ctrl); wb_valid = 1'(wv); wb_wen = 1'(ww); wb_des = IW'(wd);
    wb_data = 32'(wdat); flush = 1'(fl); out_ready = 1'(ordy);
  endtask

  function automatic bit src_ok(input logic [4:0] i, input bit u);
    return !u || i == 0 || mcnt[i] == 0 || (mcnt[i] == 1 && wb_valid && wb_wen && wb_des == i);
  endfunction

  function automatic void opnd(input logic [4:0] i, output logic [31:0] d, output bit k);
    if (i == 0) begin d = 0; k = 1; end
    else if (wb_valid && wb_wen && wb_des == i) begin d = wb_data; k = 1; end
    else begin d = mrf[i]; k = mknown[i]; end
  endfunction

  // checks the current cycle against the model, then advances model and DUT across one edge
  task automatic tick();
    bit er, iss, k1, k2, kill;
    logic [31:0] d1, d2;
    int nv;
    #2;
    er = !flush && src_ok(in_rs1, in_uses_rs1) && src_ok(in_rs2, in_uses_rs2) &&
         !(in_rd_wen && mcnt[in_rd] == CMAX) && (!mv || out_ready);
    chk("in_ready", int'(in_ready), int'(er));
    chk("out_valid", int'(out_valid), int'(mv));
    chk("err", int'(err), int'(merr));
    if (mv) begin
      chk("out_rd", int'(out_rd), int'(mrd));
      chk("out_rd_wen", int'(out_rd_wen), int'(mrw));
      chk("out_ctrl", out_ctrl, mctrl);
      if (mk1) chk("out_rs1_data", out_rs1_data, md1);
      if (mk2) chk("out_rs2_data", out_rs2_data, md2);
    end
    iss = in_valid && er;
    opnd(in_rs1, d1, k1);
    opnd(in_rs2, d2, k2);
    kill = flush && mv && mrw;
    @(posedge clk);
    if (!rst_n) begin
      foreach (mcnt[r]) mcnt[r] = 0;
      mv = 0; merr = 0; mrd = 0; mrw = 0; mctrl = 0; md1 = 0; md2 = 0; mk1 = 1; mk2 = 1;
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        nv = mcnt[r] + int'(iss && in_rd_wen && in_rd == r) - int'(wb_valid && wb_des == r)
           - int'(kill && mrd == r);
        if (nv < 0) begin nv = 0; merr = 1; end
        mcnt[r] = nv;
      end
      if (wb_valid && wb_wen && wb_des != 0) begin mrf[wb_des] = wb_data; mknown[wb_des] = 1; end
      if (flush) mv = 0;
      else if (iss) begin
        mv = 1; mrd = in_rd; mrw = in_rd_wen; mctrl = in_ctrl;
        md1 = d1; md2 = d2; mk1 = k1; mk2 = k2;
      end else if (out_ready) mv = 0;
    end
    #1;
  endtask

  initial begin
    vt[0] = '{1, 0, 0, 5, 1, 0, 0, 0, 0,       1, 1, 0, 0};
    vt[1] = '{0, 0, 0, 0, 0, 1, 1, 5, 'h1234,  1, 0, 0, 0};
    vt[2] = '{1, 5, 1, 1, 0, 0, 0, 0, 0,       1, 1, 1, 'h1234};
    vt[3] = '{1, 0, 0, 3, 1, 0, 0, 0, 0,       1, 1, 0, 0};
    vt[4] = '{1, 3, 1, 0, 0, 0, 0, 0, 0,       0, 0, 0, 0};
    vt[5] = '{1, 3, 1, 0, 0, 1, 1, 3, 'hAA,    1, 1, 1, 'hAA};
    vt[6] = '{1, 0, 0, 7, 1, 0, 0, 0, 0,       1, 1, 0, 0};
    vt[7] = '{1, 0, 0, 7, 1, 0, 0, 0, 0,       1, 1, 0, 0};
    vt[8] = '{1, 7, 1, 0, 0, 1, 1, 7, 'h11,    0, 0, 0, 0};
    vt[9] = '{1, 7, 1, 0, 0, 1, 1, 7, 'h55,    1, 1, 1, 'h55};
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    tick();
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_out_ctrl", out_ctrl, 0);
    chk("rst_out_rs1", out_rs1_data, 0);
    rst_n = 1'b1;
    foreach (vt[i]) begin
      drive(vt[i].iv, vt[i].rs1, vt[i].u1, 0, 0, vt[i].rd, vt[i].rw, i,
            vt[i].wv, vt[i].ww, vt[i].wd, vt[i].wdat, 0, 1);
      #2;
      chk("vec_in_ready", int'(in_ready), vt[i].ir);
      tick();
      chk("vec_out_valid", int'(out_valid), vt[i].ov);
      if (vt[i].c1 != 0) chk("vec_rs1_data", out_rs1_data, vt[i].d1);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    chk("drain_out_valid", int'(out_valid), 0);
    // backpressure: packet holds and issue stalls until out_ready returns
    drive(1, 0, 0, 0, 0, 2, 1, 'hA, 0, 0, 0, 0, 0, 0);
    tick();
    chk("bp_out_valid", int'(out_valid), 1);
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 0, 0, 0, 0, 0, 'hB, 0, 0, 0, 0, 0, 0);
      #2;
      chk("bp_in_ready", int'(in_ready), 0);
      tick();
      chk("bp_ctrl_stable", out_ctrl, 'hA);
      chk("bp_rd_stable", int'(out_rd), 2);
    end
    drive(1, 0, 0, 0, 0, 0, 0, 'hB, 0, 0, 0, 0, 0, 1);
    #2;
    chk("bp_release_ready", int'(in_ready), 1);
    tick();
    chk("bp_next_ctrl", out_ctrl, 'hB);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2, 0, 0, 1);
    tick();
    // flush kills the rd=x9 packet and releases its scoreboard entry
    drive(1, 0, 0, 0, 0, 9, 1, 'hC, 0, 0, 0, 0, 0, 1);
    tick();
    chk("fl_out_rd", int'(out_rd), 9);
    drive(1, 9, 1, 0, 0, 0, 0, 'hD, 0, 0, 0, 0, 1, 1);
    #2;
    chk("fl_in_ready", int'(in_ready), 0);
    tick();
    chk("fl_out_valid", int'(out_valid), 0);
    drive(1, 9, 1, 0, 0, 0, 0, 'hD, 0, 0, 0, 0, 0, 1);
    #2;
    chk("fl_reader_ready", int'(in_ready), 1);
    tick();
    chk("fl_reader_ctrl", out_ctrl, 'hD);
    // counter saturation blocks a further writer of the same register only
    for (int k = 0; k < CMAX; k++) begin
      drive(1, 0, 0, 0, 0, 6, 1, k, 0, 0, 0, 0, 0, 1);
      tick();
    end
    drive(1, 0, 0, 0, 0, 6, 1, 'hE, 0, 0, 0, 0, 0, 1);
    #2;
    chk("sat_in_ready", int'(in_ready), 0);
    tick();
    drive(1, 0, 0, 0, 0, 1, 1, 'hF, 0, 0, 0, 0, 0, 1);
    #2;
    chk("sat_other_rd_ready", int'(in_ready), 1);
    tick();
    for (int k = 0; k < CMAX; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 6, 0, 0, 1);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 'h77, 0, 1);
    tick();
    chk("no_err_yet", int'(err), 0);
    // underflow on x4 sets sticky err; x0 writes are ignored
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 4, 'h99, 0, 1);
    tick();
    chk("err_set", int'(err), 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 'h0DEAD, 0, 1);
    tick();
    chk("err_sticky", int'(err), 1);
    drive(1, 0, 1, 0, 1, 0, 0, 'h10, 0, 0, 0, 0, 0, 1);
    tick();
    chk("x0_rs1", out_rs1_data, 0);
    chk("x0_rs2", out_rs2_data, 0);
    chk("err_still", int'(err), 1);
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    rst_n = 1'b1;
    chk("rst2_err", int'(err), 0);
    chk("rst2_out_valid", int'(out_valid), 0);
    for (int n = 0; n < 3000; n++) begin
      int r;
      int wv;
      r = int'($urandom_range(1, 7));
      wv = int'(mcnt[r] > 0 && $urandom_range(0, 1) == 1);
      drive(int'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 1)), int'($urandom), wv, int'($urandom_range(0, 3) != 0), r,
            int'($urandom), int'($urandom_range(0, 15) == 0), int'($urandom_range(0, 3) != 0));
      tick();
    end
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
